// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack
//  Brief    : Program counter with clock-enable, absolute jump, and
//             call/return through an internal LIFO return-address stack.
//             Drives the ROM address bus from the instruction decoder strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_stack #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    // Depth counter must represent 0..DEPTH; stack index only 0..DEPTH-1.
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] C_DEPTH = DW'(DEPTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_en;

    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] w_inc;
    logic [DW-1:0]    w_depth_m1;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_pop_idx;
    logic             w_full;
    logic             w_empty;

    // The pushed return address and the plain increment share the same
    // modulo-2**WIDTH adder.
    assign w_inc      = q_q + 1'b1;
    assign w_depth_m1 = depth_q - 1'b1;
    assign w_push_idx = depth_q[AW-1:0];
    assign w_pop_idx  = w_depth_m1[AW-1:0];
    assign w_full     = (depth_q == C_DEPTH);
    assign w_empty    = (depth_q == '0);

    // Next-state selection: one operation per enabled cycle, ret > call > load > inc.
    always_comb begin
        q_d     = q_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (en) begin
            if (ret) begin
                if (!w_empty) begin
                    q_d     = stack_q[w_pop_idx];
                    depth_d = w_depth_m1;
                end else begin
                    // Popping an empty stack falls through to a normal advance.
                    q_d   = w_inc;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                q_d = data_in;
                if (!w_full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + 1'b1;
                end else begin
                    // Jump still happens; only the return address is lost.
                    ovf_d = 1'b1;
                end
            end else if (load) begin
                q_d = data_in;
            end else begin
                q_d = w_inc;
            end
        end
    end

    // PC, depth and sticky error flags; reset wins over any strobe on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q     <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stack_q[w_push_idx] <= w_inc;
        end
    end

    assign q         = q_q;
    assign depth     = depth_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stack
//  Brief    : Directed self-checking bench for pc_stack (4/4 and 8/2 builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack;

    logic clk;

    // 4-bit PC, 4-entry stack, reset vector 0
    logic       reset4, en4, load4, call4, ret4;
    logic [3:0] din4, q4;
    logic [2:0] depth4;
    logic       full4, empty4, ovf4, unf4;

    // 8-bit PC, 2-entry stack, reset vector A5
    logic       reset8, en8, load8, call8, ret8;
    logic [7:0] din8, q8;
    logic [1:0] depth8;
    logic       full8, empty8, ovf8, unf8;

    int tests;
    int fails;

    pc_stack #(.WIDTH(4), .DEPTH(4), .RESET_VEC(4'h0)) u_dut4 (
        .clk(clk), .reset(reset4), .en(en4), .load(load4), .call(call4),
        .ret(ret4), .data_in(din4), .q(q4), .depth(depth4), .full(full4),
        .empty(empty4), .overflow(ovf4), .underflow(unf4)
    );

    pc_stack #(.WIDTH(8), .DEPTH(2), .RESET_VEC(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset8), .en(en8), .load(load8), .call(call8),
        .ret(ret8), .data_in(din8), .q(q8), .depth(depth8), .full(full8),
        .empty(empty8), .overflow(ovf8), .underflow(unf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set4(input logic e, input logic l, input logic c, input logic r,
                        input logic [3:0] d);
        en4 = e; load4 = l; call4 = c; ret4 = r; din4 = d;
    endtask

    task automatic set8(input logic e, input logic l, input logic c, input logic r,
                        input logic [7:0] d);
        en8 = e; load8 = l; call8 = c; ret8 = r; din8 = d;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset4 = 1'b0; reset8 = 1'b0;
        set4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        set8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);

        // 1: reset and free-running count with wrap
        tick(); tick();
        chk("rst_q", q4, 4'h0);
        chk("rst_depth", depth4, 3'd0);
        chk("rst_empty", empty4, 1'b1);
        chk("rst_full", full4, 1'b0);
        chk("rst_ovf", ovf4, 1'b0);
        chk("rst_unf", unf4, 1'b0);
        chk("rst8_q", q8, 8'hA5);
        reset4 = 1'b1;
        set4(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("count", q4, 32'(i % 16));
        end

        // 2: enable hold and jump
        set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
        tick();
        chk("load5", q4, 4'd5);
        set4(1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", q4, 4'd5);
            chk("hold_depth", depth4, 3'd0);
        end
        set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd12);
        tick();
        chk("jump12", q4, 4'd12);
        set4(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        chk("inc13", q4, 4'd13);

        // 3: call / return
        set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        tick();
        chk("load3", q4, 4'd3);
        set4(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        tick();
        chk("call_q", q4, 4'd9);
        chk("call_depth", depth4, 3'd1);
        chk("call_empty", empty4, 1'b0);
        set4(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); tick();
        chk("inc11", q4, 4'd11);
        set4(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        chk("ret_q", q4, 4'd4);
        chk("ret_depth", depth4, 3'd0);
        chk("ret_empty", empty4, 1'b1);

        // 4: nesting to full, then overflow, then unwind
        set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        set4(1'b1, 1'b0, 1'b1, 1'b0, 4'd10);
        tick(); tick(); tick();
        chk("nest3_depth", depth4, 3'd3);
        chk("nest3_full", full4, 1'b0);
        tick();
        chk("nest4_full", full4, 1'b1);
        chk("nest4_depth", depth4, 3'd4);
        chk("nest4_ovf", ovf4, 1'b0);
        tick();
        chk("ovf_q", q4, 4'd10);
        chk("ovf_flag", ovf4, 1'b1);
        chk("ovf_depth", depth4, 3'd4);
        set4(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick(); chk("pop1", q4, 4'd11);
        tick(); chk("pop2", q4, 4'd11);
        tick(); chk("pop3", q4, 4'd11);
        tick(); chk("pop4", q4, 4'd1);
        chk("pop_empty", empty4, 1'b1);

        // 5: underflow and strobe priority
        tick();
        chk("unf_q", q4, 4'd2);
        chk("unf_flag", unf4, 1'b1);
        chk("unf_depth", depth4, 3'd0);
        set4(1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
        tick();
        chk("pcall_q", q4, 4'd7);
        set4(1'b1, 1'b1, 1'b1, 1'b1, 4'd14);
        tick();
        chk("prio_ret_q", q4, 4'd3);
        chk("prio_ret_depth", depth4, 3'd0);
        set4(1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
        tick();
        chk("prio_call_q", q4, 4'd6);
        chk("prio_call_depth", depth4, 3'd1);
        chk("sticky_ovf", ovf4, 1'b1);
        chk("sticky_unf", unf4, 1'b1);

        // 6: reset in the middle of a call
        set4(1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        tick();
        chk("mid_depth2", depth4, 3'd2);
        reset4 = 1'b0;
        set4(1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        chk("mid_rst_q", q4, 4'h0);
        chk("mid_rst_depth", depth4, 3'd0);
        chk("mid_rst_ovf", ovf4, 1'b0);
        chk("mid_rst_unf", unf4, 1'b0);
        chk("mid_rst_empty", empty4, 1'b1);
        reset4 = 1'b1;
        set4(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // 6b: 8-bit build, wrap at FF and wrapped return address
        reset8 = 1'b1;
        set8(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        chk("w8_load", q8, 8'hFF);
        set8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("w8_wrap", q8, 8'h00);
        set8(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        set8(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        tick();
        chk("w8_call1", q8, 8'h20);
        set8(1'b1, 1'b0, 1'b1, 1'b0, 8'h30);
        tick();
        chk("w8_full", full8, 1'b1);
        chk("w8_depth", depth8, 2'd2);
        set8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("w8_ret1", q8, 8'h21);
        tick();
        chk("w8_ret2", q8, 8'h00);
        set8(1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        tick(); tick(); tick();
        chk("w8_ovf", ovf8, 1'b1);
        chk("w8_ovf_depth", depth8, 2'd2);
        reset8 = 1'b0;
        tick();
        chk("w8_rst_q", q8, 8'hA5);
        chk("w8_rst_depth", depth8, 2'd0);
        chk("w8_rst_ovf", ovf8, 1'b0);
        reset8 = 1'b1;
        set8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
